run_sequencer: RTL and testbench

RUN_SEQUENCER -- requirements
Module: run_sequencer

---
 rtl/run_sequencer_pkg.sv | 6 +
 rtl/run_sequencer.sv | 73 +++++++
 tb/tb_run_sequencer.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/run_sequencer_pkg.sv
// run_sequencer_pkg: shared state encoding and default sizing for the run sequencer.
package run_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, CLEAR, ARMED, RUN, DONE} state_e;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int DEF_CNT_W     = 16;
endpackage

// File: rtl/run_sequencer.sv
// run_sequencer: clears data memory, then gates core execution until halt or restart.
module run_sequencer
  import run_sequencer_pkg::*;
#(
  parameter int MEM_DEPTH = DEF_MEM_DEPTH,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                         CLK,
  input  logic                         RST_n,
  input  logic                         start,
  input  logic                         halt_instr,
  output logic                         pc_init,
  output logic                         run_en,
  output logic                         clr_we,
  output logic [$clog2(MEM_DEPTH)-1:0] clr_addr,
  output logic [7:0]                   clr_data,
  output logic                         halt,
  output logic [CNT_W-1:0]             cycle_cnt
);
  localparam int AW = $clog2(MEM_DEPTH);
  state_e           state_q, state_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last;
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
    end
  end
  assign last = addr_q == AW'(MEM_DEPTH - 1);
  // restart from RUN wins over a simultaneous halt_instr
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = CLEAR;
        addr_d  = '0;
        cnt_d   = '0;
      end
      CLEAR: begin
        addr_d = last ? '0 : addr_q + 1'b1;
        if (last) state_d = start ? ARMED : RUN;
      end
      ARMED: if (!start) state_d = RUN;
      RUN: if (start) begin
        state_d = CLEAR;
        addr_d  = '0;
        cnt_d   = '0;
      end else begin
        cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        if (halt_instr) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    pc_init   = state_q != RUN;
    run_en    = state_q == RUN;
    clr_we    = state_q == CLEAR;
    halt      = state_q == DONE;
    clr_addr  = addr_q;
    clr_data  = 8'h00;
    cycle_cnt = cnt_q;
  end
endmodule

// File: tb/tb_run_sequencer.sv
// tb_run_sequencer: directed stimulus with a queue-based scoreboard for clear writes and halt counts.
module tb_run_sequencer;
  localparam int MD = 256;
  localparam int CW = 4;
  logic          CLK = 1'b0;
  logic          RST_n = 1'b0;
  logic          start = 1'b0;
  logic          halt_instr = 1'b0;
  logic          pc_init, run_en, clr_we, halt;
  logic [7:0]    clr_addr;
  logic [7:0]    clr_data;
  logic [CW-1:0] cycle_cnt;
  int            n_cmp = 0;
  int            n_err = 0;
  int            exp_addr[$];
  int            exp_cnt[$];
  logic          halt_prev = 1'b0;

  run_sequencer #(.MEM_DEPTH(MD), .CNT_W(CW)) dut (
    .CLK(CLK), .RST_n(RST_n), .start(start), .halt_instr(halt_instr),
    .pc_init(pc_init), .run_en(run_en), .clr_we(clr_we), .clr_addr(clr_addr),
    .clr_data(clr_data), .halt(halt), .cycle_cnt(cycle_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic push_addrs(input int lo, input int hi);
    for (int a = lo; a <= hi; a++) exp_addr.push_back(a);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pc_init"}, pc_init, 1);
    check({tag, "_run_en"}, run_en, 0);
    check({tag, "_clr_we"}, clr_we, 0);
    check({tag, "_clr_addr"}, clr_addr, 0);
    check({tag, "_clr_data"}, clr_data, 0);
    check({tag, "_halt"}, halt, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
  endtask

  always @(negedge CLK) begin
    if (clr_we) begin
      if (exp_addr.size() == 0) check("unexpected_clr_we", clr_we, 0);
      else check("clr_addr", clr_addr, exp_addr.pop_front());
      check("clr_data", clr_data, 0);
    end
    if (halt && !halt_prev) begin
      if (exp_cnt.size() == 0) check("unexpected_halt", halt, 0);
      else check("halt_cycle_cnt", cycle_cnt, exp_cnt.pop_front());
    end
    halt_prev = halt;
  end

  initial begin
    #12;
    check_reset_vals("reset");
    @(posedge CLK);
    #1 RST_n = 1'b1;
    push_addrs(0, MD - 1);
    start = 1'b1;
    tick(300);
    check("armed_clr_we", clr_we, 0);
    check("armed_pc_init", pc_init, 1);
    check("armed_run_en", run_en, 0);
    check("armed_all_cleared", exp_addr.size(), 0);
    start = 1'b0;
    tick();
    check("run_en_after_armed", run_en, 1);
    check("pc_init_drop", pc_init, 0);
    check("run_cnt_start", cycle_cnt, 0);
    tick(9);
    check("run_cnt_10th", cycle_cnt, 9);
    halt_instr = 1'b1;
    exp_cnt.push_back(10);
    tick();
    halt_instr = 1'b0;
    check("done_halt", halt, 1);
    check("done_run_en", run_en, 0);
    check("done_pc_init", pc_init, 1);
    for (int i = 0; i < 50; i++) begin
      halt_instr = i[0];
      tick();
      check("done_hold_halt", halt, 1);
      check("done_hold_cnt", cycle_cnt, 10);
    end
    halt_instr = 1'b0;
    push_addrs(0, MD - 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_halt", halt, 0);
    check("restart_cnt", cycle_cnt, 0);
    check("restart_clr_we", clr_we, 1);
    tick(255);
    check("last_clr_addr", clr_addr, MD - 1);
    check("last_clr_we", clr_we, 1);
    tick();
    check("direct_run", run_en, 1);
    check("direct_run_clr_we", clr_we, 0);
    check("direct_run_cnt", cycle_cnt, 0);
    tick(19);
    check("sat_cnt", cycle_cnt, 15);
    tick();
    check("sat_cnt_hold", cycle_cnt, 15);
    check("sat_run_en", run_en, 1);
    push_addrs(0, 99);
    start = 1'b1;
    halt_instr = 1'b1;
    tick();
    halt_instr = 1'b0;
    check("abort_halt", halt, 0);
    check("abort_cnt", cycle_cnt, 0);
    check("abort_clr_we", clr_we, 1);
    check("abort_run_en", run_en, 0);
    for (int i = 0; i < 100; i++) begin
      start = i[0];
      tick();
    end
    start = 1'b0;
    check("mid_clr_addr", clr_addr, 100);
    #2 RST_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    tick(3);
    RST_n = 1'b1;
    tick(20);
    check("no_resume_clr_we", clr_we, 0);
    check("no_resume_pc_init", pc_init, 1);
    check("no_resume_halt", halt, 0);
    check("addr_queue_empty", exp_addr.size(), 0);
    check("cnt_queue_empty", exp_cnt.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
